// File: rtl/mem_ld.sv
// MEM-stage load unit: waits on the data-cache response, extracts the addressed lane and builds the WB/forwarding buses.
// Optional build macro MEM_ALIGN_EXC_EN adds a misaligned-load exception output (mem_excp).
module mem_ld #(
  parameter int DC_TO_MEM_WD = 147,
  parameter int MEM_TO_WB_WD = 136
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [5:0]              stall,
  input  logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus,
  output logic                    stallreq_for_mem
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic                    mem_excp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic [4:0]  mem_op;
  logic [65:0] hilo_bus;
  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;

  assign mem_op       = dc_to_mem_bus[146:142];
  assign hilo_bus     = dc_to_mem_bus[141:76];
  assign pc           = dc_to_mem_bus[75:44];
  assign data_ram_en  = dc_to_mem_bus[43];
  assign data_ram_wen = dc_to_mem_bus[42:39];
  assign sel_rf_res   = dc_to_mem_bus[38];
  assign rf_we        = dc_to_mem_bus[37];
  assign rf_waddr     = dc_to_mem_bus[36:32];
  assign alu_result   = dc_to_mem_bus[31:0];

  logic is_load_raw, is_load, stop, rvalid;
  logic rf_we_out;

  assign is_load_raw = data_ram_en & (data_ram_wen == 4'b0000) & (|mem_op);
  assign stop        = stall[5];
  assign rvalid      = data_sram_rvalid;

`ifdef MEM_ALIGN_EXC_EN
  logic misalign;
  // A misaligned load was never issued to the cache, so it must not wait for a response.
  assign misalign  = ((mem_op[2] | mem_op[3]) & alu_result[0]) |
                     (mem_op[4] & (|alu_result[1:0]));
  assign is_load   = is_load_raw & ~misalign;
  assign mem_excp  = is_load_raw & misalign;
  assign rf_we_out = rf_we & ~mem_excp;
`else
  assign is_load   = is_load_raw;
  assign rf_we_out = rf_we;
`endif

  logic unused_bits;
  assign unused_bits = ^{stall[4:0], mem_op[4]};

  logic stallreq;
  logic use_buf;
  logic kill_data;

  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    stallreq    = 1'b0;
    use_buf     = 1'b0;
    kill_data   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          if (rvalid) begin
            if (stop) begin
              rdata_buf_d = data_sram_rdata;
              state_d     = S_HOLD;
            end
          end else begin
            stallreq = 1'b1;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rvalid) begin
          rdata_buf_d = data_sram_rdata;
          state_d     = stop ? S_HOLD : S_IDLE;
        end else begin
          stallreq = 1'b1;
        end
      end
      S_HOLD: begin
        use_buf = 1'b1;
        if (!stop) state_d = S_IDLE;
      end
      S_DROP: begin
        // The response arriving here belongs to the flushed load; the
        // current load has not been answered yet even when rvalid is high.
        kill_data = 1'b1;
        stallreq  = is_load;
        if (rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      if ((state_q == S_WAIT && !rvalid) || state_q == S_DROP) state_d = S_DROP;
      else state_d = S_IDLE;
    end
  end

  assign stallreq_for_mem = stallreq & ~rst;

  logic [31:0] src;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign src = use_buf ? rdata_buf_q : (kill_data ? 32'h0 : data_sram_rdata);

  always_comb begin
    lane_b = src[7:0];
    case (alu_result[1:0])
      2'd0: lane_b = src[7:0];
      2'd1: lane_b = src[15:8];
      2'd2: lane_b = src[23:16];
      2'd3: lane_b = src[31:24];
      default: lane_b = src[7:0];
    endcase
    lane_h = alu_result[1] ? src[31:16] : src[15:0];
    if (mem_op[0])      load_data = {{24{lane_b[7]}}, lane_b};
    else if (mem_op[1]) load_data = {24'h0, lane_b};
    else if (mem_op[2]) load_data = {{16{lane_h[15]}}, lane_h};
    else if (mem_op[3]) load_data = {16'h0, lane_h};
    else                load_data = src;
  end

  assign rf_wdata      = sel_rf_res ? load_data : alu_result;
  assign mem_to_rf_bus = {rf_we_out, rf_waddr, rf_wdata};
  assign mem_to_wb_bus = {hilo_bus, pc, rf_we_out, rf_waddr, rf_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdata_buf_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

endmodule

// File: tb/tb_mem_ld.sv
// Scoreboard bench for mem_ld: expected rf_wdata queued at issue, compared when the stage retires.
module tb_mem_ld;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic [5:0]   stall;
  logic [146:0] dc_bus;
  logic [31:0]  rdata;
  logic         rvalid;
  logic [135:0] mem_to_wb_bus;
  logic [37:0]  mem_to_rf_bus;
  logic         stallreq_for_mem;
`ifdef MEM_ALIGN_EXC_EN
  logic         mem_excp;
`endif

  mem_ld dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .stall            (stall),
    .dc_to_mem_bus    (dc_bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_rf_bus    (mem_to_rf_bus),
    .stallreq_for_mem (stallreq_for_mem)
`ifdef MEM_ALIGN_EXC_EN
    ,
    .mem_excp         (mem_excp)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [4:0]  OP_LB = 5'b00001, OP_LBU = 5'b00010, OP_LH = 5'b00100,
                          OP_LHU = 5'b01000, OP_LW = 5'b10000;
  localparam logic [65:0] HILO = 66'h2_0000_1234_5678_9ABC;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]  exp_q[$];
  logic         instr_v;
  logic         consumed;
  int           stall_cnt;
  logic [31:0]  obs_wdata;
  logic         obs_stallreq;
  logic [1:0]   obs_state;
  logic [135:0] obs_wb;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] exp;
    int          dly;
  } ld_t;
  ld_t tbl[6];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [146:0] mk(input logic [4:0] op, input logic en, input logic [3:0] wen,
                                      input logic sel, input logic we, input logic [4:0] wa,
                                      input logic [31:0] alu, input logic [31:0] pc);
    return {op, HILO, pc, en, wen, sel, we, wa, alu};
  endfunction

  task automatic tick();
    @(negedge clk);
    obs_wdata    = mem_to_rf_bus[31:0];
    obs_stallreq = stallreq_for_mem;
    obs_state    = dut.state_q;
    obs_wb       = mem_to_wb_bus;
    consumed     = 1'b0;
    if (instr_v && !flush) begin
      if (stallreq_for_mem) stall_cnt++;
      else if (!stall[5]) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("rf_wdata", {32'h0, obs_wdata}, {32'h0, exp_q.pop_front()});
        consumed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [146:0] b, input logic [31:0] e);
    dc_bus    = b;
    instr_v   = 1'b1;
    stall_cnt = 0;
    exp_q.push_back(e);
  endtask

  task automatic idle_bus();
    dc_bus  = '0;
    instr_v = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0;
  endtask

  task automatic run_load(input string tag, input logic [146:0] b, input int dly,
                          input logic [31:0] rd, input logic [31:0] e);
    bit done;
    done = 1'b0;
    put(b, e);
    for (int i = 0; i < 20; i++) begin
      rvalid = (i == dly);
      rdata  = (i == dly) ? rd : 32'h0;
      tick();
      if (consumed) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_stalls"}, stall_cnt, dly);
    idle_bus();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'h0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", dut.state_q, 0);
    check("rst_buf", dut.rdata_buf_q, 0);
    check("rst_stallreq", stallreq_for_mem, 0);
    check("rst_rf_bus", mem_to_rf_bus, 0);
    check("rst_wb_bus", |mem_to_wb_bus, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // same-cycle LB from the top byte, sign-extended
    run_load("lb3", mk(OP_LB, 1, 0, 1, 1, 5'd3, 32'h0000_1003, 32'hBFC0_0100), 0,
             32'h80FF_FF12, 32'hFFFF_FF80);

    tbl[0] = '{OP_LHU, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF, 3};
    tbl[1] = '{OP_LH,  32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001, 1};
    tbl[2] = '{OP_LH,  32'h0000_2000, 32'h1234_8765, 32'hFFFF_8765, 0};
    tbl[3] = '{OP_LBU, 32'h0000_2001, 32'h0000_9A00, 32'h0000_009A, 2};
    tbl[4] = '{OP_LB,  32'h0000_2000, 32'h0000_007F, 32'h0000_007F, 0};
    tbl[5] = '{OP_LW,  32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 2};
    for (int k = 0; k < 6; k++)
      run_load($sformatf("ld%0d", k), mk(tbl[k].op, 1, 0, 1, 1, 5'd4, tbl[k].addr, 32'h100 + k),
               tbl[k].dly, tbl[k].rd, tbl[k].exp);

    // response in WAIT while WB holds -> HOLD keeps the captured word
    put(mk(OP_LW, 1, 0, 1, 1, 5'd5, 32'h0000_3000, 32'h200), 32'hDEAD_BEEF);
    rvalid = 1'b0;
    tick();
    check("hold_wait_stall", obs_stallreq, 1);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; stall = 6'b100000;
    tick();
    check("hold_c0_data", obs_wdata, 32'hDEAD_BEEF);
    check("hold_c0_stall", obs_stallreq, 0);
    rvalid = 1'b0; rdata = 32'h0;
    tick();
    check("hold_c1_state", obs_state, 2);
    check("hold_c1_data", obs_wdata, 32'hDEAD_BEEF);
    stall = 6'h0;
    tick();
    check("hold_release", consumed, 1);
    check("hold_exit_state", dut.state_q, 0);
    idle_bus();

    // same-cycle response while WB holds -> captured in IDLE
    put(mk(OP_LW, 1, 0, 1, 1, 5'd6, 32'h0000_7000, 32'h204), 32'h5A5A_0F0F);
    rvalid = 1'b1; rdata = 32'h5A5A_0F0F; stall = 6'b100000;
    tick();
    check("idle_hold_stall", obs_stallreq, 0);
    check("idle_hold_state", dut.state_q, 2);
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF; stall = 6'h0;
    tick();
    check("idle_hold_release", consumed, 1);
    idle_bus();

    // flush in WAIT, then a new LW must skip the stale response
    dc_bus = mk(OP_LW, 1, 0, 1, 1, 5'd8, 32'h0000_4000, 32'h300);
    instr_v = 1'b0; rvalid = 1'b0;
    tick();
    check("fl_wait_stall", obs_stallreq, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_drop_state", dut.state_q, 3);
    put(mk(OP_LW, 1, 0, 1, 1, 5'd9, 32'h0000_5000, 32'h304), 32'h2222_2222);
    tick();
    check("fl_new_stall0", obs_stallreq, 1);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick();
    check("fl_stale_stall", obs_stallreq, 1);
    check("fl_stale_hidden", obs_wdata == 32'h1111_1111, 0);
    check("fl_after_drop", dut.state_q, 0);
    rvalid = 1'b0; rdata = 32'h0;
    tick();
    check("fl_new_stall2", obs_stallreq, 1);
    rvalid = 1'b1; rdata = 32'h2222_2222;
    tick();
    check("fl_new_done", consumed, 1);
    idle_bus();

    // ALU result with rvalid noise: never stalls, never leaves IDLE
    for (int i = 0; i < 4; i++) begin
      put(mk(5'b0, 0, 0, 0, 1, 5'd7, 32'h0000_0042, 32'h400 + 4 * i), 32'h0000_0042);
      rvalid = i[0];
      rdata  = $urandom;
      tick();
      check("alu_done", consumed, 1);
      check("alu_stall", obs_stallreq, 0);
      check("alu_state", obs_state, 0);
      check("alu_pc", obs_wb[69:38], 32'h400 + 4 * i);
    end
    check("alu_hilo", obs_wb[135:70], HILO);
    check("alu_we_waddr", obs_wb[37:32], {1'b1, 5'd7});

    // store with a load opcode bit set still does not stall
    put(mk(OP_LW, 1, 4'hF, 0, 0, 5'd0, 32'h0000_0088, 32'h500), 32'h0000_0088);
    rvalid = 1'b0;
    tick();
    check("store_done", consumed, 1);
    check("store_stall", obs_stallreq, 0);
    idle_bus();

    // async reset while waiting
    dc_bus = mk(OP_LW, 1, 0, 1, 1, 5'd10, 32'h0000_6000, 32'h600);
    rvalid = 1'b0;
    tick();
    check("rstw_state", dut.state_q, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_state_idle", dut.state_q, 0);
    check("rstw_stallreq", stallreq_for_mem, 0);
    check("rstw_buf", dut.rdata_buf_q, 0);
    idle_bus();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("rstw_rf_we", mem_to_rf_bus[37], 0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
